alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Two-requester scheduler that shares one external 32-bit ALU instance (AND/OR/NAND/add/sub/mul, 3-bit sel, enable, result out).
- Arbitrates operation requests round-robin and drives the ALU operand, sel and enable lines for a fixed number of cycles.
- Captures the ALU result and returns it to the winning requester over a valid/ready response channel tagged with the requester ID.

Parameters:
- W, 32: operand/result width; must match the ALU.
- LAT, 1: EXEC cycles for non-multiply ops (>=1).
- MUL_LAT, 2: EXEC cycles for multiply, sel=3'b111 (>=1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  3  requester 0 ALU sel code.
- req0_a  input  W  requester 0 operand a.
- req0_b  input  W  requester 0 operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, for requester 1.
- alu_a  output  W  operand a to ALU.
- alu_b  output  W  operand b to ALU.
- alu_sel  output  3  sel to ALU.
- alu_enable  output  1  ALU enable.
- alu_salida  input  W  ALU result.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester that issued the command.
- rsp_data  output  W  captured result.
- rsp_err  output  1  illegal op code.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE, RR pointer = 0 (requester 0 has priority).
  - alu_a, alu_b, alu_sel, alu_enable = 0.
  - rsp_valid, rsp_id, rsp_data, rsp_err = 0.
  - req*_ready = 0 while rst is high.
  - Reset mid-operation aborts the command with no response.
- Legal ops: 000, 001, 100, 010, 011, 111. Ops 101 and 110 are illegal.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the RR pointer.
  - reqN_ready = (state==IDLE) && grantN. This is combinational, so at most one ready is asserted per cycle.
  - On handshake:
    - Register a, b, op into alu_a/alu_b/alu_sel and the ID into rsp_id.
    - RR pointer <= ~ID.
    - Counter <= (op==111 ? MUL_LAT : LAT) - 1.
    - Legal op: go to EXEC. Illegal op: go to DONE with rsp_err=1, rsp_data=0, and alu_enable stays 0.
- EXEC:
  - alu_enable=1. Operand and sel registers are held stable.
  - Counter decrements each cycle.
  - On the cycle the counter == 0: rsp_data <= alu_salida, rsp_err <= 0, then go to DONE.
  - alu_enable returns to 0 in DONE.
- DONE:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are stable until the handshake.
  - On rsp_ready: go to IDLE, rsp_valid=0.
  - No new command is accepted in EXEC or DONE; req*_ready=0.
- Latency:
  - Handshake at cycle T gives EXEC on T+1..T+L and rsp_valid from T+L+1, where L = LAT or MUL_LAT.
  - With rsp_ready held high, back-to-back period is L+2 cycles.
  - An illegal op gives rsp_valid at T+1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Arithmetic: the block performs no computation. rsp_data is exactly the W-bit alu_salida, with wrap and truncation as produced by the ALU.
- Requester inputs are sampled only on the handshake cycle. Changes afterwards have no effect.

Test Plan:
- Reset, then req0 op=010, a=5, b=7 (LAT=1) -> req0_ready in the accept cycle; alu_enable for 1 cycle with alu_sel=010; rsp_valid next cycle with rsp_data=12, rsp_id=0, rsp_err=0.
- req1 op=111, a=6, b=7 (MUL_LAT=2) -> alu_enable for 2 cycles; rsp_data=42, rsp_id=1; rsp_valid 3 cycles after the handshake.
- req0 and req1 both held valid, op=000 and op=001, a=F0F0F0F0, b=0FF00FF0, rsp_ready=1 -> grants 0,1,0,1; responses alternate between 00F000F0 (id 0) and FFF0FFF0 (id 1).
- req0 op=101 -> rsp_valid the cycle after the handshake with rsp_err=1, rsp_data=0; alu_enable never asserts.
- op=011, a=0, b=1, with rsp_ready held low for 5 cycles -> rsp_data=FFFFFFFF held stable with rsp_valid high; req*_ready stays 0 until rsp_ready.
- Assert rst during EXEC -> next cycle: state IDLE, alu_enable=0, rsp_valid=0, RR pointer=0; no response is emitted.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bundle of requester, ALU and response signals shared between the sequencer and its environment.
// Latency: none, wires only.
// Backpressure: valid/ready on both request channels and on the response channel.
interface alu_sequencer_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;

    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic         alu_enable;
    logic [W-1:0] alu_salida;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    // Sequencer side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_salida, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel, alu_enable,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    // Requesters, ALU and response consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_salida, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel, alu_enable,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Round-robin scheduler sharing one external ALU between two requesters, result returned with requester ID.
// Latency: response valid L+1 cycles after accept (L = LAT, or MUL_LAT for sel 111); illegal op after 1 cycle.
// Backpressure: one command in flight; both request readys stay low until the response is taken.
module alu_sequencer #(
    parameter int W       = 32,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    localparam int MAXL = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(LAT - 1);
    localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       state_q;
    state_t       state_d;
    logic         rr_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [2:0]   sel_q;
    logic         id_q;
    logic [W-1:0] data_q;
    logic         err_q;

    logic         grant_id;
    logic         any_valid;
    logic         hs;
    logic [2:0]   win_op;
    logic [W-1:0] win_a;
    logic [W-1:0] win_b;
    logic         win_legal;

    // Pick the winner: a lone valid requester wins, a tie goes to the round-robin pointer
    always_comb begin
        grant_id = rr_q;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant_id = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant_id = 1'b1;
        end
    end

    assign any_valid      = bus.req0_valid || bus.req1_valid;
    assign bus.req0_ready = !rst && (state_q == IDLE) && any_valid && !grant_id;
    assign bus.req1_ready = !rst && (state_q == IDLE) && any_valid && grant_id;
    assign hs             = bus.req0_ready || bus.req1_ready;

    assign win_op    = grant_id ? bus.req1_op : bus.req0_op;
    assign win_a     = grant_id ? bus.req1_a  : bus.req0_a;
    assign win_b     = grant_id ? bus.req1_b  : bus.req0_b;
    assign win_legal = !((win_op == 3'b101) || (win_op == 3'b110));

    // Next-state logic: illegal ops skip the ALU and go straight to the response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = win_legal ? EXEC : DONE;
            EXEC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Command capture on accept, cycle counting and result capture on the last EXEC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            id_q   <= 1'b0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && hs) begin
                a_q   <= win_a;
                b_q   <= win_b;
                sel_q <= win_op;
                id_q  <= grant_id;
                rr_q  <= ~grant_id;
                cnt_q <= (win_op == 3'b111) ? MUL_M1 : LAT_M1;
                if (!win_legal) begin
                    err_q  <= 1'b1;
                    data_q <= '0;
                end
            end else if (state_q == EXEC) begin
                if (cnt_q == '0) begin
                    data_q <= bus.alu_salida;
                    err_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_sel    = sel_q;
    assign bus.alu_enable = (state_q == EXEC);
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
endmodule
